// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional feature macro: DMEM_OOR_ERR_EN (out-of-range error response).
package dmem_responder_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Value loaded into the wait counter on accept; unused when latency is zero.
    function automatic logic [CNT_W-1:0] wait_load(input int latency);
        if (latency == 0) begin
            return {CNT_W{1'b0}};
        end else begin
            return CNT_W'(latency - 1);
        end
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH x 32 word store: synchronous write, registered read.
// The read register doubles as the response data register of the responder.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic              clk,
    input  logic              rn,
    input  logic              we,
    input  logic              re,
    input  logic              clr,
    input  logic [AW-1:0]     idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Array write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[idx] <= wdata;
        end
    end

    // Read register: zeroed for store/error responses, loaded on a read commit.
    always_ff @(posedge clk) begin
        if (!rn) begin
            rdata <= {DATA_W{1'b0}};
        end else if (clr) begin
            rdata <= {DATA_W{1'b0}};
        end else if (re) begin
            rdata <= mem_r[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the core load/store port.
// One request at a time, fixed access latency, valid/ready on both sides.
// Optional feature macro: DMEM_OOR_ERR_EN adds rsp_err and suppresses
// array access for addresses >= DEPTH instead of wrapping.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_we,
    output logic              busy
`ifdef DMEM_OOR_ERR_EN
    ,
    output logic              rsp_err
`endif
);

    localparam logic [CNT_W-1:0] LAT_LOAD = wait_load(LATENCY);

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              lat_we_r;
    logic [AW-1:0]     lat_idx_r;
    logic [DATA_W-1:0] lat_wdata_r;

    logic              commit_s;
    logic              c_we_s;
    logic [AW-1:0]     c_idx_s;
    logic [DATA_W-1:0] c_wdata_s;
    logic              c_oor_s;
    logic              req_oor_s;

`ifdef DMEM_OOR_ERR_EN
    logic              lat_oor_r;

    assign req_oor_s = (req_addr >= ADDR_W'(DEPTH));
`else
    // Upper address bits are deliberately ignored: addresses wrap modulo DEPTH.
    logic              unused_addr_s;

    assign unused_addr_s = ^req_addr[ADDR_W-1:AW];
    assign req_oor_s     = 1'b0;
`endif

    // Select the access to commit this edge: the live request for zero latency,
    // otherwise the latched request once the wait counter has expired.
    always_comb begin
        commit_s  = 1'b0;
        c_we_s    = lat_we_r;
        c_idx_s   = lat_idx_r;
        c_wdata_s = lat_wdata_r;
`ifdef DMEM_OOR_ERR_EN
        c_oor_s   = lat_oor_r;
`else
        c_oor_s   = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if ((LATENCY == 0) && req_valid) begin
                    commit_s  = rn;
                    c_we_s    = req_we;
                    c_idx_s   = req_addr[AW-1:0];
                    c_wdata_s = req_wdata;
                    c_oor_s   = req_oor_s;
                end else begin
                    commit_s  = 1'b0;
                end
            end
            ST_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    commit_s = rn;
                end else begin
                    commit_s = 1'b0;
                end
            end
            default: begin
                commit_s = 1'b0;
            end
        endcase
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .rn    (rn),
        .we    (commit_s & c_we_s & ~c_oor_s),
        .re    (commit_s & ~c_we_s & ~c_oor_s),
        .clr   (commit_s & (c_we_s | c_oor_s)),
        .idx   (c_idx_s),
        .wdata (c_wdata_s),
        .rdata (rsp_rdata)
    );

    // Control FSM with wait counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            lat_we_r    <= 1'b0;
            lat_idx_r   <= {AW{1'b0}};
            lat_wdata_r <= {DATA_W{1'b0}};
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_we      <= 1'b0;
            busy        <= 1'b0;
`ifdef DMEM_OOR_ERR_EN
            lat_oor_r   <= 1'b0;
            rsp_err     <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_we_r    <= req_we;
                        lat_idx_r   <= req_addr[AW-1:0];
                        lat_wdata_r <= req_wdata;
`ifdef DMEM_OOR_ERR_EN
                        lat_oor_r   <= req_oor_s;
`endif
                        req_ready   <= 1'b0;
                        busy        <= 1'b1;
                        if (LATENCY == 0) begin
                            state_r   <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_we    <= req_we;
`ifdef DMEM_OOR_ERR_EN
                            rsp_err   <= req_oor_s;
`endif
                        end else begin
                            state_r   <= ST_WAIT;
                            cnt_r     <= LAT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_we    <= lat_we_r;
`ifdef DMEM_OOR_ERR_EN
                        rsp_err   <= lat_oor_r;
`endif
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r   <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
